register_tree_core: RTL and testbench
=====================================

# register_tree_core

Register-based binary max-heap that keeps its largest value on `o_data`. It supports a single operation, replace-top: the current maximum is discarded, a new value is inserted, and the heap is re-sorted by a one-level-per-cycle sift-down. It sits in the hardware priority-queue family as the flat-register, fixed-occupancy reference implementation. All nodes are always occupied; there is no empty or full state.

## Interface
- `QUEUE_SIZE`, default 8: number of nonzero seed entries loaded at reset.
- `DATA_WIDTH`, default 32: element width in bits; elements are unsigned.
- `TREE_DEPTH`, derived as `$clog2(QUEUE_SIZE+1)` (4 by default): number of levels.
- `NODES_NEEDED`, derived as `2**TREE_DEPTH-1` (15 by default): number of node registers.
- `COMP_COUNT`, derived as `NODES_NEEDED/2` (7 by default): number of internal (parent) nodes.
- `CLK` input, 1 bit: the single clock; all state is updated on its rising edge.
- `RSTn` input, 1 bit: reset, asynchronous and active-low.
- `i_replace` input, 1 bit: replace-top request, sampled on the rising edge of `CLK`.
- `i_data` input, `DATA_WIDTH` bits: value to insert; valid while `i_replace` is 1.
- `o_data` output, `DATA_WIDTH` bits: current root, which is the heap maximum once sorting has settled.

## Operation
- Storage: `node[0..NODES_NEEDED-1]`, with node 0 as the root.
  - The children of node i are 2i+1 and 2i+2.
  - Level of node i is floor(log2(i+1)).
- Reset values, applied asynchronously:
  - `node[i] = (QUEUE_SIZE-i)*10` for i ≤ `QUEUE_SIZE`; `node[i] = 0` otherwise.
  - With defaults: 80, 70, 60, 50, 40, 30, 20, 10, 0, 0, 0, 0, 0, 0, 0. This is already a valid max-heap.
  - `o_data` = 80.
  - `busy` = 0; `level` = 0; `pos` = 0.
- Replace, when `i_replace`=1 and `busy`=0 at a clock edge:
  - `node[0] <= i_data`; the old root is discarded.
  - `busy <= 1`, `pos <= 0`, `level <= 0`.
- Sift-down, one step per cycle while `busy`=1:
  - Let L=2·pos+1 and R=2·pos+2. The larger child C is L if `node[L] >= node[R]`, else R.
  - If `node[C] > node[pos]`: swap the two nodes and set `pos <= C`.
  - Otherwise clear `busy`; no swap.
  - Always clear `busy` after the step taken at level `TREE_DEPTH-2`, the last parent level.
- Comparisons are unsigned and `DATA_WIDTH` bits wide.
  - Equal child and parent: no swap.
  - Equal children: the left child wins.
- `i_replace` while `busy`=1 is ignored; the request is dropped and no state changes. Callers must space requests at least `TREE_DEPTH` cycles apart.
- Invariant: when `busy`=0, every parent is ≥ both of its children, so `node[0]` holds the maximum of all `NODES_NEEDED` values.
- The multiset of stored values is always the reset set, minus each popped maximum, plus each inserted value.

## Timing
- `o_data` is driven directly from `node[0]`; there is no combinational path from the inputs.
- Edge E0 samples `i_replace`: after E0, `o_data` = `i_data`, which is transiently unsorted.
- Edge E1 performs the root-level step: `o_data` becomes the true maximum.
- Edges E2..E(`TREE_DEPTH`-1) perform the deeper steps.
  - With defaults, the heap is fully restored after E3.
  - A new `i_replace` is accepted at E4 or later.
- Asserting `RSTn` low mid-sift aborts the sift and restores the seed values immediately.

## Structure
- Package `register_tree_pkg` holds the seed-value function (index → reset value) and the child-index helper functions.
- Sub-module `register_tree_cmp`: purely combinational; takes parent, left and right; outputs the larger-child select and a swap flag.
  - Instantiate `COMP_COUNT` copies, one per parent node, or one copy muxed by `pos`.
- Top level contains the node array, the `busy`/`pos`/`level` registers and the swap write-back.

## Test plan
- Reset, defaults: after `RSTn` deasserts, `o_data`=80 and it holds across 3 idle cycles.
- Single replace with `i_data`=5: `o_data`=5 after E0, 70 after E1, and stays 70. The stored set loses 80 and gains 5.
- Replace with a larger value, `i_data`=200: `o_data`=200 from E0 on, with no swaps.
- 8 spaced replaces with random values in 1..256, 4 cycles apart: after each request, compare `o_data` against a software queue (pop max, push value, resort) → match every time and after 4 further idle cycles.
- Back-to-back `i_replace` (1 at E0 and at E1): the second request is ignored; the result equals a single replace.
- Reset mid-sift: pulse `RSTn` low after E1 → `o_data`=80 immediately; a subsequent replace behaves as from fresh reset.

Source files
------------

// File: rtl/register_tree_pkg.sv
// Shared helpers for the register max-heap: seed values and child indexing.
// Latency: n/a (pure functions, elaborated or evaluated combinationally).
// Backpressure: n/a.
package register_tree_pkg;

    // Reset value of node idx for a queue seeded with qsize entries:
    // a descending ramp (qsize*10 down to 0), zero beyond the seeded range.
    function automatic int seed_value(input int idx, input int qsize);
        return (idx <= qsize) ? (qsize - idx) * 10 : 0;
    endfunction

    function automatic int left_child(input int idx);
        return 2 * idx + 1;
    endfunction

    function automatic int right_child(input int idx);
        return 2 * idx + 2;
    endfunction

endpackage

// File: rtl/register_tree_cmp.sv
// Compare one parent against its two children for a sift-down step.
// Latency: combinational, zero cycles.
// Backpressure: none.
//
// Ports: parent/left/right node values in; sel_right picks the larger child
// (left wins ties); swap is set when that child is strictly above the parent.
module register_tree_cmp #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] parent,
    input  logic [DATA_WIDTH-1:0] left,
    input  logic [DATA_WIDTH-1:0] right,
    output logic                  sel_right,
    output logic                  swap
);

    logic [DATA_WIDTH-1:0] child;

    always_comb begin
        sel_right = (left < right);
        child     = sel_right ? right : left;
        swap      = (child > parent);
    end

endmodule

// File: rtl/register_tree_core.sv
// Flat-register binary max-heap with a replace-top operation; root on o_data.
// Latency: o_data = i_data one edge after request, true max one edge later; heap settled after TREE_DEPTH edges.
// Backpressure: none; requests arriving while a sift is in progress are dropped.
//
// Ports: CLK, RSTn (async active-low), i_replace/i_data (replace-top request
// and value), o_data (current root, registered).
module register_tree_core
    import register_tree_pkg::*;
#(
    parameter int QUEUE_SIZE = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  i_replace,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data
);

    localparam int TREE_DEPTH   = $clog2(QUEUE_SIZE + 1);
    localparam int NODES_NEEDED = 2 ** TREE_DEPTH - 1;
    localparam int COMP_COUNT   = NODES_NEEDED / 2;
    localparam int POS_W        = (NODES_NEEDED > 1) ? $clog2(NODES_NEEDED) : 1;
    localparam int LVL_W        = (TREE_DEPTH > 1) ? $clog2(TREE_DEPTH) : 1;
    localparam logic [LVL_W-1:0] LAST_LVL = LVL_W'(TREE_DEPTH - 2);

    logic [DATA_WIDTH-1:0] node [NODES_NEEDED];
    logic                  busy;
    logic [POS_W-1:0]      pos;
    logic [LVL_W-1:0]      level;

    logic [POS_W-1:0]      l_idx;
    logic [POS_W-1:0]      r_idx;
    logic [POS_W-1:0]      c_idx;
    logic                  sel_right;
    logic                  swap;

    // Child indices are only meaningful while pos is a parent; once the sift
    // has walked onto a leaf they are parked at 0 so the array is never
    // indexed out of range.
    always_comb begin
        l_idx = '0;
        r_idx = '0;
        if (int'(pos) < COMP_COUNT) begin
            l_idx = POS_W'(left_child(int'(pos)));
            r_idx = POS_W'(right_child(int'(pos)));
        end
        c_idx = sel_right ? r_idx : l_idx;
    end

    // One comparator shared across levels, steered by the current position.
    register_tree_cmp #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cmp (
        .parent    (node[pos]),
        .left      (node[l_idx]),
        .right     (node[r_idx]),
        .sel_right (sel_right),
        .swap      (swap)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < NODES_NEEDED; i++) begin
                node[i] <= DATA_WIDTH'(seed_value(i, QUEUE_SIZE));
            end
            busy  <= 1'b0;
            pos   <= '0;
            level <= '0;
        end else if (!busy) begin
            if (i_replace) begin
                node[0] <= i_data;
                busy    <= 1'b1;
                pos     <= '0;
                level   <= '0;
            end
        end else begin
            if (swap) begin
                node[pos]   <= node[c_idx];
                node[c_idx] <= node[pos];
                pos         <= c_idx;
            end
            // Stop early when the heap order already holds, and always after
            // the last parent level since there is nothing below it.
            if (!swap || level == LAST_LVL) begin
                busy <= 1'b0;
            end else begin
                level <= level + 1'b1;
            end
        end
    end

    assign o_data = node[0];

endmodule

// File: tb/tb_register_tree_core.sv
module tb_register_tree_core;

    localparam int DW = 32;
    localparam int NN = 15;

    logic          CLK;
    logic          RSTn;
    logic          i_replace;
    logic [DW-1:0] i_data;
    logic [DW-1:0] o_data;

    int errors;
    int checks;

    // Reference multiset of stored values.
    int unsigned mdl [$];

    register_tree_core #(
        .QUEUE_SIZE (8),
        .DATA_WIDTH (DW)
    ) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .i_replace (i_replace),
        .i_data    (i_data),
        .o_data    (o_data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic void model_reset();
        mdl.delete();
        for (int i = 0; i < NN; i++) begin
            mdl.push_back((i <= 8) ? (8 - i) * 10 : 0);
        end
    endfunction

    function automatic int unsigned model_max();
        int unsigned m;
        m = 0;
        foreach (mdl[i]) if (mdl[i] > m) m = mdl[i];
        return m;
    endfunction

    function automatic void model_replace(input int unsigned v);
        int unsigned m;
        m = model_max();
        for (int i = 0; i < mdl.size(); i++) begin
            if (mdl[i] == m) begin
                mdl.delete(i);
                break;
            end
        end
        mdl.push_back(v);
    endfunction

    task automatic apply_reset();
        i_replace = 1'b0;
        i_data    = '0;
        @(negedge CLK);
        RSTn = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;
        model_reset();
    endtask

    // Issue one replace and check o_data after E0 (raw value), after E1
    // (true maximum) and once settled after E3. Returns after E3 + 1.
    task automatic do_replace(input int unsigned v, input string name);
        i_replace = 1'b1;
        i_data    = v;
        @(posedge CLK); #1;
        i_replace = 1'b0;
        checks++;
        if (o_data !== v) begin
            errors++;
            $display("FAIL %s E0: o_data=%0d expected=%0d", name, o_data, v);
        end
        model_replace(v);
        @(posedge CLK); #1;
        checks++;
        if (o_data !== model_max()) begin
            errors++;
            $display("FAIL %s E1: o_data=%0d expected=%0d", name, o_data, model_max());
        end
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (o_data !== model_max()) begin
            errors++;
            $display("FAIL %s settled: o_data=%0d expected=%0d", name, o_data, model_max());
        end
    endtask

    // Pop every stored value by inserting zeros; the maxima must come out in
    // the model's order, which verifies the whole stored multiset.
    task automatic drain(input string name);
        for (int k = 0; k < NN; k++) begin
            do_replace(0, name);
        end
    endtask

    task automatic test_reset();
        i_replace = 1'b0;
        i_data    = '0;
        RSTn      = 1'b0;
        #12;
        checks++;
        if (o_data !== 80) begin
            errors++;
            $display("FAIL reset_asserted: o_data=%0d expected=80", o_data);
        end
        @(negedge CLK);
        RSTn = 1'b1;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK); #1;
            checks++;
            if (o_data !== 80) begin
                errors++;
                $display("FAIL reset_idle%0d: o_data=%0d expected=80", c, o_data);
            end
        end
    endtask

    task automatic test_single_small();
        apply_reset();
        do_replace(5, "single5");
        if (model_max() != 70) $display("note: model max %0d", model_max());
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (o_data !== 70) begin
            errors++;
            $display("FAIL single5_hold: o_data=%0d expected=70", o_data);
        end
        drain("single5_drain");
    endtask

    task automatic test_large();
        apply_reset();
        do_replace(200, "large200");
        drain("large200_drain");
    endtask

    task automatic test_spaced();
        int unsigned vals [8];
        vals = '{137, 3, 256, 71, 70, 1, 199, 64};
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            do_replace(vals[k], $sformatf("spaced%0d", k));
        end
        repeat (4) @(posedge CLK);
        #1;
        checks++;
        if (o_data !== model_max()) begin
            errors++;
            $display("FAIL spaced_idle: o_data=%0d expected=%0d", o_data, model_max());
        end
        drain("spaced_drain");
    endtask

    task automatic test_back_to_back();
        apply_reset();
        i_replace = 1'b1;
        i_data    = 9;
        @(posedge CLK); #1;
        checks++;
        if (o_data !== 9) begin
            errors++;
            $display("FAIL b2b_E0: o_data=%0d expected=9", o_data);
        end
        model_replace(9);
        i_data = 300;
        @(posedge CLK); #1;
        i_replace = 1'b0;
        checks++;
        if (o_data !== 70) begin
            errors++;
            $display("FAIL b2b_E1: o_data=%0d expected=70", o_data);
        end
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (o_data !== 70) begin
            errors++;
            $display("FAIL b2b_settled: o_data=%0d expected=70", o_data);
        end
        drain("b2b_drain");
    endtask

    task automatic test_reset_mid_sift();
        apply_reset();
        i_replace = 1'b1;
        i_data    = 5;
        @(posedge CLK); #1;
        i_replace = 1'b0;
        @(posedge CLK); #1;
        RSTn = 1'b0;
        #1;
        checks++;
        if (o_data !== 80) begin
            errors++;
            $display("FAIL midsift_reset: o_data=%0d expected=80", o_data);
        end
        @(negedge CLK);
        RSTn = 1'b1;
        model_reset();
        @(posedge CLK); #1;
        checks++;
        if (o_data !== 80) begin
            errors++;
            $display("FAIL midsift_after: o_data=%0d expected=80", o_data);
        end
        do_replace(5, "midsift_replace");
        drain("midsift_drain");
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        RSTn      = 1'b0;
        i_replace = 1'b0;
        i_data    = '0;
        test_reset();
        test_single_small();
        test_large();
        test_spaced();
        test_back_to_back();
        test_reset_mid_sift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
